mesh_mix_sequencer: RTL and testbench

MESH_MIX_SEQUENCER -- requirements
Module: mesh_mix_sequencer

---
 rtl/mesh_seq_pkg.sv | 21 ++
 rtl/mesh_dwell_counter.sv | 45 ++++
 rtl/mesh_mix_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_mesh_mix_sequencer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mesh_seq_pkg.sv
// -----------------------------------------------------------------------------
// mesh_seq_pkg
// Shared definitions for the mesh mix sequencer:
//   - default values for the channel count, mesh depth and cycle-count width
//   - the sequencer state enumeration
// -----------------------------------------------------------------------------
package mesh_seq_pkg;

   localparam int N_CH_DEFAULT  = 8;   // inlet/outlet channel count
   localparam int DEPTH_DEFAULT = 3;   // diffmix stages in the mesh
   localparam int CNT_W_DEFAULT = 8;   // width of load/dwell cycle counts

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_MIX   = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } mesh_state_e;

endpackage : mesh_seq_pkg

// File: rtl/mesh_dwell_counter.sv
// -----------------------------------------------------------------------------
// mesh_dwell_counter
// Loadable down-counter used to time every phase of a mix run.
//   clk       in   clock, rising edge
//   rst_n     in   synchronous active-low reset (count cleared to 0)
//   load      in   load load_val on the next edge (0 is loaded as 1)
//   load_val  in   phase length in cycles
//   expired   out  high during the last cycle of the loaded phase
// The count stops at 1 and never wraps; it is reloaded on every phase entry.
// -----------------------------------------------------------------------------
module mesh_dwell_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             expired
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         // A zero length still occupies one cycle.
         count_d = (load_val == '0) ? CNT_W'(1) : load_val;
      end else if (count_q > CNT_W'(1)) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // A phase loaded with N cycles sees count N..1; the cycle at 1 is its last.
   assign expired = (count_q == CNT_W'(1));

endmodule : mesh_dwell_counter

// File: rtl/mesh_mix_sequencer.sv
// -----------------------------------------------------------------------------
// mesh_mix_sequencer
// Sequences one microfluidic mix run: LOAD (inlets open), MIX (one stage gate
// at a time through DEPTH stages), DRAIN (all outlets open), DONE (one pulse).
//   clk           in   clock, rising edge
//   rst_n         in   synchronous active-low reset
//   start         in   request a run (sampled in IDLE only)
//   abort         in   flush a run in LOAD or MIX straight to DRAIN
//   in_mask       in   inlets to open for the run
//   load_cycles   in   LOAD and DRAIN length in cycles (0 treated as 1)
//   dwell_cycles  in   per-stage MIX length in cycles (0 treated as 1)
//   inlet_valve   out  inlet enables, latched mask during LOAD
//   stage_valve   out  one-hot stage gate during MIX
//   outlet_valve  out  all-ones during DRAIN
//   stage_idx     out  current stage + 1 during MIX, else 0
//   busy          out  high outside IDLE
//   done          out  one-cycle pulse in DONE
//   aborted       out  sticky abort flag, valid with done, cleared in IDLE
//   err           out  one-cycle pulse when a start with an empty mask is refused
// All outputs are flops whose next value is derived from the next state, so
// each output is aligned with the state it describes.
// -----------------------------------------------------------------------------
module mesh_mix_sequencer
   import mesh_seq_pkg::*;
#(
   parameter int N_CH  = N_CH_DEFAULT,
   parameter int DEPTH = DEPTH_DEFAULT,
   parameter int CNT_W = CNT_W_DEFAULT
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     abort,
   input  logic [N_CH-1:0]          in_mask,
   input  logic [CNT_W-1:0]         load_cycles,
   input  logic [CNT_W-1:0]         dwell_cycles,
   output logic [N_CH-1:0]          inlet_valve,
   output logic [DEPTH-1:0]         stage_valve,
   output logic [N_CH-1:0]          outlet_valve,
   output logic [$clog2(DEPTH):0]   stage_idx,
   output logic                     busy,
   output logic                     done,
   output logic                     aborted,
   output logic                     err
);

   localparam int STG_W = $clog2(DEPTH) + 1;
   localparam logic [STG_W-1:0] LAST_STAGE = STG_W'(DEPTH - 1);

   // Sequencer state and run context
   mesh_state_e       state_q, state_d;
   logic [N_CH-1:0]   mask_q, mask_d;
   logic [CNT_W-1:0]  load_q, load_d;
   logic [CNT_W-1:0]  dwell_q, dwell_d;
   logic [STG_W-1:0]  stage_q, stage_d;
   logic              aborted_q, aborted_d;

   // Registered outputs
   logic [N_CH-1:0]   inlet_valve_q, inlet_valve_d;
   logic [DEPTH-1:0]  stage_valve_q, stage_valve_d;
   logic [N_CH-1:0]   outlet_valve_q, outlet_valve_d;
   logic [STG_W-1:0]  stage_idx_q, stage_idx_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   // Shared phase timer
   logic              cnt_load;
   logic [CNT_W-1:0]  cnt_val;
   logic              cnt_expired;

   mesh_dwell_counter #(
      .CNT_W (CNT_W)
   ) u_dwell_counter (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (cnt_load),
      .load_val (cnt_val),
      .expired  (cnt_expired)
   );

   // Next-state logic. Every phase entry reloads the shared timer.
   always_comb begin
      state_d   = state_q;
      mask_d    = mask_q;
      load_d    = load_q;
      dwell_d   = dwell_q;
      stage_d   = stage_q;
      aborted_d = aborted_q;
      err_d     = 1'b0;
      cnt_load  = 1'b0;
      cnt_val   = load_q;

      case (state_q)
         ST_IDLE: begin
            // start takes priority over abort here; abort has no meaning in IDLE.
            if (start) begin
               if (in_mask != '0) begin
                  state_d  = ST_LOAD;
                  mask_d   = in_mask;
                  load_d   = load_cycles;
                  dwell_d  = dwell_cycles;
                  stage_d  = '0;
                  cnt_load = 1'b1;
                  cnt_val  = load_cycles;
               end else begin
                  err_d = 1'b1;
               end
            end
         end

         ST_LOAD: begin
            if (abort) begin
               state_d   = ST_DRAIN;
               aborted_d = 1'b1;
               cnt_load  = 1'b1;
               cnt_val   = load_q;
            end else if (cnt_expired) begin
               state_d  = ST_MIX;
               stage_d  = '0;
               cnt_load = 1'b1;
               cnt_val  = dwell_q;
            end
         end

         ST_MIX: begin
            if (abort) begin
               state_d   = ST_DRAIN;
               aborted_d = 1'b1;
               cnt_load  = 1'b1;
               cnt_val   = load_q;
            end else if (cnt_expired) begin
               cnt_load = 1'b1;
               if (stage_q == LAST_STAGE) begin
                  state_d = ST_DRAIN;
                  cnt_val = load_q;
               end else begin
                  stage_d = stage_q + STG_W'(1);
                  cnt_val = dwell_q;
               end
            end
         end

         ST_DRAIN: begin
            if (cnt_expired) begin
               state_d = ST_DONE;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // The abort flag only lives for the duration of one run.
      if (state_d == ST_IDLE) begin
         aborted_d = 1'b0;
      end
   end

   // Output decode from the next state: each valve group is nonzero only in
   // its own state, so the groups are mutually exclusive by construction.
   always_comb begin
      inlet_valve_d  = (state_d == ST_LOAD)  ? mask_d : '0;
      outlet_valve_d = (state_d == ST_DRAIN) ? '1     : '0;
      stage_idx_d    = (state_d == ST_MIX)   ? (stage_d + STG_W'(1)) : '0;
      busy_d         = (state_d != ST_IDLE);
      done_d         = (state_d == ST_DONE);
   end

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage_gate
         assign stage_valve_d[gi] = (state_d == ST_MIX) && (stage_d == STG_W'(gi));
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         mask_q         <= '0;
         load_q         <= '0;
         dwell_q        <= '0;
         stage_q        <= '0;
         aborted_q      <= 1'b0;
         inlet_valve_q  <= '0;
         stage_valve_q  <= '0;
         outlet_valve_q <= '0;
         stage_idx_q    <= '0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         err_q          <= 1'b0;
      end else begin
         state_q        <= state_d;
         mask_q         <= mask_d;
         load_q         <= load_d;
         dwell_q        <= dwell_d;
         stage_q        <= stage_d;
         aborted_q      <= aborted_d;
         inlet_valve_q  <= inlet_valve_d;
         stage_valve_q  <= stage_valve_d;
         outlet_valve_q <= outlet_valve_d;
         stage_idx_q    <= stage_idx_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         err_q          <= err_d;
      end
   end

   assign inlet_valve  = inlet_valve_q;
   assign stage_valve  = stage_valve_q;
   assign outlet_valve = outlet_valve_q;
   assign stage_idx    = stage_idx_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign aborted      = aborted_q;
   assign err          = err_q;

endmodule : mesh_mix_sequencer

// File: tb/tb_mesh_mix_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mesh_mix_sequencer
// Self-checking bench for mesh_mix_sequencer (N_CH=8, DEPTH=3, CNT_W=8).
// Expected outputs for each cycle of a run come from a timeline model that
// computes the phase from the cycle offset after the start cycle.
// -----------------------------------------------------------------------------
module tb_mesh_mix_sequencer;

   localparam int N_CH  = 8;
   localparam int DEPTH = 3;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic             abort;
   logic [N_CH-1:0]  in_mask;
   logic [CNT_W-1:0] load_cycles;
   logic [CNT_W-1:0] dwell_cycles;
   logic [N_CH-1:0]  inlet_valve;
   logic [DEPTH-1:0] stage_valve;
   logic [N_CH-1:0]  outlet_valve;
   logic [2:0]       stage_idx;
   logic             busy;
   logic             done;
   logic             aborted;
   logic             err;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mesh_mix_sequencer #(
      .N_CH  (N_CH),
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .abort        (abort),
      .in_mask      (in_mask),
      .load_cycles  (load_cycles),
      .dwell_cycles (dwell_cycles),
      .inlet_valve  (inlet_valve),
      .stage_valve  (stage_valve),
      .outlet_valve (outlet_valve),
      .stage_idx    (stage_idx),
      .busy         (busy),
      .done         (done),
      .aborted      (aborted),
      .err          (err)
   );

   typedef struct packed {
      logic [7:0] inlet;
      logic [2:0] stage;
      logic [7:0] outlet;
      logic [2:0] idx;
      logic       busy;
      logic       done;
      logic       aborted;
      logic       err;
   } outs_t;

   typedef struct {
      string      name;
      logic [7:0] mask;
      logic [7:0] l;
      logic [7:0] w;
      int         abort_at;   // cycle offset where abort is held high, 0 = none
      int         exp_done;   // expected cycle offset of the done pulse
   } vec_t;

   function automatic outs_t sample_dut();
      outs_t o;
      o.inlet   = inlet_valve;
      o.stage   = stage_valve;
      o.outlet  = outlet_valve;
      o.idx     = stage_idx;
      o.busy    = busy;
      o.done    = done;
      o.aborted = aborted;
      o.err     = err;
      return o;
   endfunction

   task automatic check(input string name, input int t, input outs_t exp);
      outs_t act;
      act = sample_dut();
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0d actual in=%h st=%b out=%h idx=%0d busy=%b done=%b ab=%b err=%b required in=%h st=%b out=%h idx=%0d busy=%b done=%b ab=%b err=%b",
                  name, t, act.inlet, act.stage, act.outlet, act.idx, act.busy, act.done, act.aborted, act.err,
                  exp.inlet, exp.stage, exp.outlet, exp.idx, exp.busy, exp.done, exp.aborted, exp.err);
      end
   endtask

   // Expected outputs t cycles after the start cycle. le/we are effective
   // (zero-promoted) lengths; a is the abort cycle or 0.
   function automatic outs_t model(input int t, input int le, input int we,
                                   input logic [7:0] mask, input int a);
      outs_t o;
      int mix_end;
      int drain_start;
      int done_t;
      int k;
      o = '0;
      mix_end     = le + DEPTH * we;
      drain_start = (a > 0) ? a + 1 : mix_end + 1;
      done_t      = drain_start + le;
      if (t >= 1 && t < drain_start) begin
         o.busy = 1'b1;
         if (t <= le) begin
            o.inlet = mask;
         end else begin
            k       = (t - le - 1) / we;
            o.stage = 3'(1 << k);
            o.idx   = 3'(k + 1);
         end
      end else if (t >= drain_start && t < done_t) begin
         o.busy    = 1'b1;
         o.outlet  = 8'hFF;
         o.aborted = (a > 0);
      end else if (t == done_t) begin
         o.busy    = 1'b1;
         o.done    = 1'b1;
         o.aborted = (a > 0);
      end
      return o;
   endfunction

   // Called in the start cycle with the DUT idle; returns positioned in the
   // idle cycle after DONE, with start left at 'hold'.
   task automatic run_job(input string tag, input logic [7:0] mask, input logic [7:0] l,
                          input logic [7:0] w, input int a, input bit scramble,
                          input bit hold, output int done_seen);
      int le;
      int we;
      int mix_end;
      int total;
      le      = (l == 0) ? 1 : int'(l);
      we      = (w == 0) ? 1 : int'(w);
      mix_end = le + DEPTH * we;
      total   = (a > 0) ? a + 1 + le : 1 + 2 * le + DEPTH * we;
      done_seen    = -1;
      start        = 1'b1;
      in_mask      = mask;
      load_cycles  = l;
      dwell_cycles = w;
      abort        = scramble ? 1'($urandom_range(0, 1)) : 1'b0;
      for (int t = 1; t <= total + 1; t++) begin
         @(posedge clk);
         #1;
         check(tag, t, model(t, le, we, mask, a));
         if (done === 1'b1 && done_seen < 0) done_seen = t;
         start = hold;
         if (scramble) begin
            in_mask      = 8'($urandom);
            load_cycles  = 8'($urandom);
            dwell_cycles = 8'($urandom);
         end
         if (a > 0)
            abort = (t == a) ? 1'b1 : ((t > a && scramble) ? 1'($urandom_range(0, 1)) : 1'b0);
         else
            abort = (t > mix_end && scramble) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      $display("run %s mask=%h L=%0d W=%0d abort_at=%0d hold=%0d done_at=%0d", tag, mask, l, w, a, hold, done_seen);
   endtask

   task automatic idle_gap(input int n);
      for (int i = 0; i < n; i++) begin
         start   = 1'b0;
         abort   = 1'($urandom_range(0, 1));
         in_mask = 8'($urandom);
         @(posedge clk);
         #1;
         check("idle_gap", i, '0);
      end
   endtask

   initial begin
      vec_t  vecs[7];
      outs_t exp;
      int    ds;
      int    le;
      int    we;
      int    a;
      bit    hold;
      logic [7:0] m, l, w;

      vecs[0] = '{"nominal",      8'hFF, 8'd4, 8'd5, 0,  24};
      vecs[1] = '{"zero_counts",  8'h81, 8'd0, 8'd0, 0,  6};
      vecs[2] = '{"abort_stage1", 8'hFF, 8'd4, 8'd5, 11, 16};
      vecs[3] = '{"abort_load",   8'h3C, 8'd4, 8'd5, 2,  7};
      vecs[4] = '{"l3_w2",        8'h5A, 8'd3, 8'd2, 0,  13};
      vecs[5] = '{"abort_last",   8'h01, 8'd2, 8'd3, 11, 14};
      vecs[6] = '{"ones",         8'h80, 8'd1, 8'd1, 0,  6};

      // Reset, with start/abort asserted to show reset dominates.
      rst_n = 1'b0; start = 1'b1; abort = 1'b1;
      in_mask = 8'hFF; load_cycles = 8'd4; dwell_cycles = 8'd5;
      repeat (3) @(posedge clk);
      #1;
      check("reset", 0, '0);
      start = 1'b0; abort = 1'b0; rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_reset_idle", 0, '0);

      // Table-driven runs.
      foreach (vecs[i]) begin
         run_job(vecs[i].name, vecs[i].mask, vecs[i].l, vecs[i].w, vecs[i].abort_at, 1'b0, 1'b0, ds);
         checks++;
         if (ds != vecs[i].exp_done) begin
            errors++;
            $display("FAIL %s_done_time actual=%0d required=%0d", vecs[i].name, ds, vecs[i].exp_done);
         end
         idle_gap(2);
      end

      // Zero mask: err pulse, stays idle.
      start = 1'b1; in_mask = 8'h00; load_cycles = 8'd3; dwell_cycles = 8'd3; abort = 1'b0;
      @(posedge clk);
      #1;
      exp = '0; exp.err = 1'b1;
      check("zero_mask_err", 1, exp);
      start = 1'b0;
      @(posedge clk);
      #1;
      check("zero_mask_after", 2, '0);
      $display("seq zero_mask err pulse checked");

      // start held high through two back-to-back runs.
      run_job("held1", 8'hFF, 8'd1, 8'd1, 0, 1'b0, 1'b1, ds);
      checks++;
      if (ds != 6) begin errors++; $display("FAIL held1_done_time actual=%0d required=6", ds); end
      run_job("held2", 8'h0F, 8'd2, 8'd1, 0, 1'b0, 1'b1, ds);
      checks++;
      if (ds != 8) begin errors++; $display("FAIL held2_done_time actual=%0d required=8", ds); end
      run_job("held3", 8'hF0, 8'd1, 8'd2, 0, 1'b0, 1'b0, ds);
      idle_gap(1);

      // Reset in MIX: outputs clear on the next cycle, no done, restart works.
      start = 1'b1; in_mask = 8'hFF; load_cycles = 8'd4; dwell_cycles = 8'd5; abort = 1'b0;
      for (int t = 1; t <= 7; t++) begin
         @(posedge clk);
         #1;
         check("pre_reset_run", t, model(t, 4, 5, 8'hFF, 0));
         start = 1'b0;
      end
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("reset_in_mix", 8, '0);
      rst_n = 1'b1;
      for (int t = 0; t < 30; t++) begin
         @(posedge clk);
         #1;
         check("no_done_after_reset", t, '0);
      end
      run_job("after_reset", 8'hFF, 8'd4, 8'd5, 0, 1'b0, 1'b0, ds);
      checks++;
      if (ds != 24) begin errors++; $display("FAIL after_reset_done_time actual=%0d required=24", ds); end

      // Randomized runs with scrambled inputs during the run.
      for (int r = 0; r < 40; r++) begin
         m  = 8'($urandom_range(1, 255));
         l  = 8'($urandom_range(0, 6));
         w  = 8'($urandom_range(0, 6));
         le = (l == 0) ? 1 : int'(l);
         we = (w == 0) ? 1 : int'(w);
         a  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, le + DEPTH * we)) : 0;
         hold = ($urandom_range(0, 3) == 0);
         run_job("random", m, l, w, a, 1'b1, hold, ds);
         if (!hold && $urandom_range(0, 1) == 1) idle_gap(int'($urandom_range(1, 3)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_mesh_mix_sequencer
